// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the slave router.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HR_OKAY  = 1'b0,
    HR_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // NONSEQ and SEQ are the only transfer types that need a data-phase response.
  function automatic logic trans_active(input logic [1:0] t);
    return (t == HT_NONSEQ) || (t == HT_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped or decode-disabled accesses: answers every active
// transfer with the two-cycle ERROR response; IDLE/BUSY get a zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dsel,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic       hreadyout,
  output logic       hresp
);

  ds_state_e state;
  logic      accept;

  assign accept = dsel && trans_active(htrans) && hready;

  // Outputs are registered next to the state so they already match it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DS_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HR_OKAY;
    end else begin
      case (state)
        DS_IDLE: begin
          if (accept) begin
            state     <= DS_ERR1;
            hreadyout <= 1'b0;
            hresp     <= HR_ERROR;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HR_ERROR;
        end
        DS_ERR2: begin
          if (accept) begin
            state     <= DS_ERR1;
            hreadyout <= 1'b0;
            hresp     <= HR_ERROR;
          end else begin
            state     <= DS_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HR_OKAY;
          end
        end
        default: begin
          state     <= DS_IDLE;
          hreadyout <= 1'b1;
          hresp     <= HR_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_router.sv
// AHB-Lite slave-side router: address-phase region decode, registered
// data-phase select and response/read-data mux, with a built-in default slave.
module ahb_slave_router
  import ahb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h4000_0000, 32'h2000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {32'hF000_0000, 32'hFF80_0000}
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      EN,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  output logic [NUM_SLV-1:0]        HSEL,
  input  logic [NUM_SLV-1:0]        HREADYOUT_S,
  input  logic [NUM_SLV-1:0]        HRESP_S,
  input  logic [NUM_SLV*DATA_W-1:0] HRDATA_S,
  output logic                      HREADY,
  output logic                      HRESP,
  output logic [DATA_W-1:0]         HRDATA
);

  localparam logic [NUM_SLV:0] DP_DEF = {1'b1, {NUM_SLV{1'b0}}};

  logic [NUM_SLV-1:0] hit;
  logic               dsel;
  logic [NUM_SLV:0]   dp_sel;
  logic               ds_ready;
  logic               ds_resp;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_dec
    assign hit[i] = (HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                    (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]);
  end

  // Walk from the top down so the lowest-index hit is the one left standing.
  always_comb begin
    HSEL = '0;
    if (EN) begin
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
        if (hit[i]) begin
          HSEL    = '0;
          HSEL[i] = 1'b1;
        end
      end
    end
  end

  assign dsel = ~|HSEL;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      dp_sel <= DP_DEF;
    else if (HREADY) dp_sel <= {dsel, HSEL};
  end

  ahb_default_slave u_dflt (
    .clk       (HCLK),
    .rst       (HRESET),
    .dsel      (dsel),
    .htrans    (HTRANS),
    .hready    (HREADY),
    .hreadyout (ds_ready),
    .hresp     (ds_resp)
  );

  // dp_sel is one-hot, so an AND-OR mux is enough.
  always_comb begin
    HREADY = dp_sel[NUM_SLV] & ds_ready;
    HRESP  = dp_sel[NUM_SLV] & ds_resp;
    HRDATA = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      HREADY = HREADY | (dp_sel[i] & HREADYOUT_S[i]);
      HRESP  = HRESP  | (dp_sel[i] & HRESP_S[i]);
      HRDATA = HRDATA | ({DATA_W{dp_sel[i]}} & HRDATA_S[i*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: tb/tb_ahb_slave_router.sv
// Scoreboard bench for ahb_slave_router: the driver queues expected HSEL and
// data-phase results, a negedge monitor pops and compares them.
module tb_ahb_slave_router;

  logic        HCLK, HRESET, EN;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [1:0]  HSEL;
  logic [1:0]  hreadyout_s, hresp_s;
  logic [63:0] hrdata_s;
  logic        HREADY, HRESP;
  logic [31:0] HRDATA;

  logic        en4;
  logic [31:0] haddr4;
  logic [3:0]  hsel4;
  logic        hready4, hresp4;
  logic [31:0] hrdata4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } dp_t;

  dp_t        exp_dp_q[$];
  logic [1:0] exp_hsel_q[$];

  ahb_slave_router dut (
    .HCLK(HCLK), .HRESET(HRESET), .EN(EN), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL(HSEL), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
    .HRDATA_S(hrdata_s), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  ahb_slave_router #(
    .NUM_SLV (4),
    .SLV_BASE({32'h3010_0000, 32'h5000_0000, 32'h3000_0000, 32'h2000_0000}),
    .SLV_MASK({32'hFFF0_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF80_0000})
  ) dut4 (
    .HCLK(HCLK), .HRESET(HRESET), .EN(en4), .HADDR(haddr4), .HTRANS(2'b00),
    .HSEL(hsel4), .HREADYOUT_S(4'hF), .HRESP_S(4'h0),
    .HRDATA_S(128'h0), .HREADY(hready4), .HRESP(hresp4), .HRDATA(hrdata4)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: checks HSEL on every accepted active address phase and the
  // outcome of every tracked data phase.
  initial begin
    bit  in_dp = 0;
    int  wcnt  = 0;
    dp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        in_dp = 0;
      end else begin
        if (in_dp) begin
          if (exp_dp_q.size() == 0) begin
            chk("dp_expectation_present", 32'd0, 32'd1);
            in_dp = 0;
          end else if (!HREADY) begin
            wcnt++;
            chk("wait_hresp", {31'd0, HRESP}, {31'd0, exp_dp_q[0].resp});
            if (wcnt > 20) begin
              chk("dp_timeout", 32'(wcnt), 32'(exp_dp_q[0].waits));
              void'(exp_dp_q.pop_front());
              in_dp = 0;
            end
          end else begin
            e = exp_dp_q.pop_front();
            chk("dp_waits", 32'(wcnt), 32'(e.waits));
            chk("dp_hresp", {31'd0, HRESP}, {31'd0, e.resp});
            chk("dp_hrdata", HRDATA, e.rdata);
            in_dp = 0;
          end
        end
        if (HREADY && HTRANS[1]) begin
          if (exp_hsel_q.size() == 0) chk("hsel_expectation_present", 32'd0, 32'd1);
          else chk("hsel", {30'd0, HSEL}, {30'd0, exp_hsel_q.pop_front()});
          in_dp = 1;
          wcnt  = 0;
        end
      end
    end
  end

  // Drive one address phase and return just after the edge that accepts it.
  task automatic xfer(input logic [31:0] a, input logic e, input logic [1:0] hs,
                      input logic [31:0] rd, input logic rs, input int w);
    bit ok = 0;
    HADDR  = a;
    HTRANS = 2'b10;
    EN     = e;
    exp_hsel_q.push_back(hs);
    exp_dp_q.push_back('{rd, rs, w});
    for (int i = 0; i < 50; i++) begin
      @(negedge HCLK);
      if (HREADY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    HTRANS = 2'b00;
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    HRESET      = 1'b1;
    EN          = 1'b1;
    HADDR       = 32'h2000_0010;
    HTRANS      = 2'b00;
    hreadyout_s = 2'b11;
    hresp_s     = 2'b00;
    hrdata_s    = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    en4         = 1'b1;
    haddr4      = 32'h0;

    #1;
    chk("rst_hready", {31'd0, HREADY}, 32'd1);
    chk("rst_hresp",  {31'd0, HRESP},  32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_hsel_comb", {30'd0, HSEL}, 32'd1);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Plain zero-wait read from slave0.
    xfer(32'h2000_0010, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b0, 0);
    idle(1);

    // Unmapped: ERROR pair, then back to OKAY.
    xfer(32'h1000_0000, 1'b1, 2'b00, 32'h0, 1'b1, 1);
    idle(3);
    chk("post_err_hready", {31'd0, HREADY}, 32'd1);
    chk("post_err_hresp",  {31'd0, HRESP},  32'd0);

    // A second error issued in ERR2 chains straight into ERR1.
    xfer(32'h1000_0000, 1'b1, 2'b00, 32'h0, 1'b1, 1);
    xfer(32'h0000_0100, 1'b1, 2'b00, 32'h0, 1'b1, 1);
    idle(3);

    // BUSY to the default slave: zero-wait OKAY.
    HADDR  = 32'h1000_0000;
    HTRANS = 2'b01;
    @(posedge HCLK);
    #1;
    chk("busy_hready", {31'd0, HREADY}, 32'd1);
    chk("busy_hresp",  {31'd0, HRESP},  32'd0);
    idle(1);

    // Back-to-back across slaves, no bubble.
    xfer(32'h2000_0000, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b0, 0);
    xfer(32'h4000_0004, 1'b1, 2'b10, 32'hCAFE_F00D, 1'b0, 0);
    xfer(32'h2000_0008, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b0, 0);
    idle(2);

    // Slave1 stalls 3 cycles while the next address targets slave0.
    xfer(32'h4000_0004, 1'b1, 2'b10, 32'hCAFE_F00D, 1'b0, 3);
    HADDR  = 32'h2000_0004;
    HTRANS = 2'b10;
    exp_hsel_q.push_back(2'b01);
    exp_dp_q.push_back('{32'hDEAD_BEEF, 1'b0, 0});
    hreadyout_s[1] = 1'b0;
    #1;
    chk("stall_hready", {31'd0, HREADY}, 32'd0);
    chk("stall_hrdata_slave1", HRDATA, 32'hCAFE_F00D);
    repeat (3) @(negedge HCLK);
    @(posedge HCLK);
    #1;
    hreadyout_s[1] = 1'b1;
    @(posedge HCLK);
    #1;
    idle(2);

    // Decode disabled: slave0 address errors; re-enabled next transfer works.
    xfer(32'h2000_0000, 1'b0, 2'b00, 32'h0, 1'b1, 1);
    xfer(32'h2000_0000, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b0, 0);
    idle(2);

    // Reset during ERR1 drops straight back to IDLE.
    xfer(32'h1000_0000, 1'b1, 2'b00, 32'h0, 1'b1, 1);
    HTRANS = 2'b00;
    chk("err1_hready", {31'd0, HREADY}, 32'd0);
    #1;
    HRESET = 1'b1;
    #1;
    chk("rst_err1_hready", {31'd0, HREADY}, 32'd1);
    chk("rst_err1_hresp",  {31'd0, HRESP},  32'd0);
    exp_dp_q.delete();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    #1;
    chk("post_rst_hready", {31'd0, HREADY}, 32'd1);
    chk("post_rst_hresp",  {31'd0, HRESP},  32'd0);
    @(posedge HCLK);
    #1;
    xfer(32'h4000_0000, 1'b1, 2'b10, 32'hCAFE_F00D, 1'b0, 0);
    idle(3);

    // Four-region instance with regions 1 and 3 overlapping.
    haddr4 = 32'h3010_0004; #1; chk("ovl_both_hit", {28'd0, hsel4}, 32'h2);
    haddr4 = 32'h3000_0000; #1; chk("ovl_r1_only",  {28'd0, hsel4}, 32'h2);
    haddr4 = 32'h5000_0010; #1; chk("r2_hit",       {28'd0, hsel4}, 32'h4);
    haddr4 = 32'h2000_0000; #1; chk("r0_hit",       {28'd0, hsel4}, 32'h1);
    haddr4 = 32'h6000_0000; #1; chk("r4_miss",      {28'd0, hsel4}, 32'h0);
    en4 = 1'b0; haddr4 = 32'h3010_0004; #1; chk("r4_en_off", {28'd0, hsel4}, 32'h0);

    chk("dp_queue_drained",   32'(exp_dp_q.size()),   32'd0);
    chk("hsel_queue_drained", 32'(exp_hsel_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
